// File: rtl/warp_write_merger.sv
// -----------------------------------------------------------------------------
// warp_write_merger
//   Splits one warp of per-lane word writes into DRAM line writes. Lanes that
//   fall in the same line form a group. Each group is folded into a single
//   line buffer. With MERGE=1 the line stays open across groups and warps
//   until a different line or a flush needs the buffer. With MERGE=0 every
//   group is written out as soon as it has been loaded.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   addrval_rdy/_ack         warp address handshake (acked jointly with data)
//   i_address [VSIZE*GBW]    word address per lane, lane i at [i*GBW +: GBW]
//   i_valid   [VSIZE]        per-lane write enable
//   alu_dat_rdy/_ack         warp data handshake
//   i_alu_dat [VSIZE*DBW]    data per lane, lane i at [i*DBW +: DBW]
//   flush_dval/flushed_dval  flush request / one-cycle completion pulse
//   dramw_rdy/dramw_ack      DRAM line write handshake
//   o_dramwa                 line-aligned word address
//   o_dramwd [CSIZE*DBW]     line data, word j at [j*DBW +: DBW]
//   o_dramw_mask [CSIZE]     word enables
//   o_nwrite                 completed DRAM writes, wraps
//
// GBW and DBW default to the global address and data widths of the system
// configuration (32 bits each).
//
// state  | meaning
// S_IDLE  | waiting for a warp or a pending flush
// S_SPLIT | forming one line group per cycle from the remaining lanes
// S_EMIT  | offering the line buffer to DRAM until dramw_ack
// S_FLUSH | emptying the buffer, then pulsing flushed_dval
// -----------------------------------------------------------------------------
module warp_write_merger #(
  parameter int VSIZE  = 32,
  parameter int CSIZE  = 32,
  parameter int GBW    = 32,
  parameter int DBW    = 32,
  parameter int MERGE  = 1,
  parameter int CNT_BW = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   addrval_rdy,
  output logic                   addrval_ack,
  input  logic [VSIZE*GBW-1:0]   i_address,
  input  logic [VSIZE-1:0]       i_valid,
  input  logic                   alu_dat_rdy,
  output logic                   alu_dat_ack,
  input  logic [VSIZE*DBW-1:0]   i_alu_dat,
  input  logic                   flush_dval,
  output logic                   flushed_dval,
  output logic                   dramw_rdy,
  input  logic                   dramw_ack,
  output logic [GBW-1:0]         o_dramwa,
  output logic [CSIZE*DBW-1:0]   o_dramwd,
  output logic [CSIZE-1:0]       o_dramw_mask,
  output logic [CNT_BW-1:0]      o_nwrite
);

  localparam int LBW = $clog2(CSIZE);
  localparam int TBW = GBW - LBW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPLIT = 2'd1,
    S_EMIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_pend;
  logic [VSIZE*GBW-1:0]   r_addr;
  logic [VSIZE*DBW-1:0]   r_data;
  logic [VSIZE-1:0]       r_rem;

  logic                   r_bv;
  logic [TBW-1:0]         r_bt;
  logic [CSIZE*DBW-1:0]   r_bd;
  logic [CSIZE-1:0]       r_bm;
  logic [CNT_BW-1:0]      r_nwrite;

  logic                   w_ack;
  logic [TBW-1:0]         w_tag;
  logic [VSIZE-1:0]       w_grp;
  logic [VSIZE-1:0]       w_rem_nxt;
  logic                   w_load;
  logic                   w_wr_done;
  logic [CSIZE*DBW-1:0]   w_bd_nxt;
  logic [CSIZE-1:0]       w_bm_nxt;

  // Tag of the lowest remaining lane, and every remaining lane sharing it.
  always_comb begin
    w_tag = '0;
    for (int i = VSIZE - 1; i >= 0; i--) begin
      if (r_rem[i]) w_tag = r_addr[i*GBW+LBW +: TBW];
    end
    w_grp = '0;
    for (int i = 0; i < VSIZE; i++) begin
      w_grp[i] = r_rem[i] && (r_addr[i*GBW+LBW +: TBW] == w_tag);
    end
  end

  // Group merged into the buffer. Lanes are scanned in ascending order so the
  // highest-index lane hitting a word is the one that lands.
  always_comb begin
    w_bd_nxt = r_bd;
    w_bm_nxt = r_bm;
    for (int j = 0; j < CSIZE; j++) begin
      for (int i = 0; i < VSIZE; i++) begin
        if (w_grp[i] && (r_addr[i*GBW +: LBW] == LBW'(j))) begin
          w_bd_nxt[j*DBW +: DBW] = r_data[i*DBW +: DBW];
          w_bm_nxt[j]            = 1'b1;
        end
      end
    end
  end

  assign w_ack     = (r_state == S_IDLE) && addrval_rdy && alu_dat_rdy && !r_pend;
  assign w_rem_nxt = r_rem & ~w_grp;
  // A group may enter the buffer when it is empty or already holds that line.
  assign w_load    = (r_state == S_SPLIT) && (r_rem != '0) &&
                     (!r_bv || ((MERGE != 0) && (r_bt == w_tag)));
  assign w_wr_done = (r_state == S_EMIT) && dramw_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pend)                       w_state_nxt = S_FLUSH;
        else if (w_ack && (i_valid != '0)) w_state_nxt = S_SPLIT;
      end
      S_SPLIT: begin
        if (r_rem == '0)                   w_state_nxt = r_pend ? S_FLUSH : S_IDLE;
        else if (!w_load || (MERGE == 0))  w_state_nxt = S_EMIT;
        else if (w_rem_nxt == '0)          w_state_nxt = r_pend ? S_FLUSH : S_IDLE;
      end
      S_EMIT: begin
        if (dramw_ack) begin
          if (r_rem != '0)  w_state_nxt = S_SPLIT;
          else if (r_pend)  w_state_nxt = S_FLUSH;
          else              w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        w_state_nxt = r_bv ? S_EMIT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend   <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_rem    <= '0;
      r_bv     <= 1'b0;
      r_bt     <= '0;
      r_bd     <= '0;
      r_bm     <= '0;
      r_nwrite <= '0;
    end else begin
      // Completion wins over a coincident request: that request is absorbed.
      if ((r_state == S_FLUSH) && !r_bv) r_pend <= 1'b0;
      else if (flush_dval)              r_pend <= 1'b1;

      if (w_ack) begin
        r_addr <= i_address;
        r_data <= i_alu_dat;
        r_rem  <= i_valid;
      end

      if (w_load) begin
        r_bd  <= w_bd_nxt;
        r_bm  <= w_bm_nxt;
        r_bt  <= w_tag;
        r_bv  <= 1'b1;
        r_rem <= w_rem_nxt;
      end

      if (w_wr_done) begin
        r_bv     <= 1'b0;
        r_bm     <= '0;
        r_nwrite <= r_nwrite + 1'b1;
      end
    end
  end

  assign addrval_ack  = w_ack;
  assign alu_dat_ack  = w_ack;
  assign flushed_dval = (r_state == S_FLUSH) && !r_bv;
  assign dramw_rdy    = (r_state == S_EMIT);
  assign o_dramwa     = {r_bt, {LBW{1'b0}}};
  assign o_dramwd     = r_bd;
  assign o_dramw_mask = r_bm;
  assign o_nwrite     = r_nwrite;

endmodule

// File: tb/tb_warp_write_merger.sv
module tb_warp_write_merger;

  localparam int V  = 4;
  localparam int C  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct {
    logic [15:0] a;
    logic [63:0] d;
    logic [3:0]  m;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        sel = 1'b1;
  logic        rdy = 1'b0;
  logic        flush = 1'b0;
  logic        dram_ack = 1'b0;
  logic        hold = 1'b0;
  logic        mon_en = 1'b0;
  logic [63:0] addr_in = '0;
  logic [3:0]  v_in = '0;
  logic [63:0] dat_in = '0;

  logic        ar0, ar1, fi0, fi1, ak0, ak1;
  logic        aack0, aack1, dack0, dack1, fl0, fl1, drdy0, drdy1;
  logic [15:0] wa0, wa1, nw0, nw1;
  logic [63:0] wd0, wd1;
  logic [3:0]  wm0, wm1;

  logic        cur_aack, cur_dack, cur_fl, cur_drdy;
  logic [15:0] cur_wa, cur_nw;
  logic [63:0] cur_wd;
  logic [3:0]  cur_wm;

  assign ar0 = rdy & ~sel;      assign ar1 = rdy & sel;
  assign fi0 = flush & ~sel;    assign fi1 = flush & sel;
  assign ak0 = dram_ack & ~sel; assign ak1 = dram_ack & sel;

  assign cur_aack = sel ? aack1 : aack0;
  assign cur_dack = sel ? dack1 : dack0;
  assign cur_fl   = sel ? fl1   : fl0;
  assign cur_drdy = sel ? drdy1 : drdy0;
  assign cur_wa   = sel ? wa1   : wa0;
  assign cur_wd   = sel ? wd1   : wd0;
  assign cur_wm   = sel ? wm1   : wm0;
  assign cur_nw   = sel ? nw1   : nw0;

  warp_write_merger #(.VSIZE(V), .CSIZE(C), .GBW(AW), .DBW(DW), .MERGE(0), .CNT_BW(16)) u_m0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .addrval_rdy(ar0), .addrval_ack(aack0), .i_address(addr_in), .i_valid(v_in),
    .alu_dat_rdy(ar0), .alu_dat_ack(dack0), .i_alu_dat(dat_in),
    .flush_dval(fi0), .flushed_dval(fl0),
    .dramw_rdy(drdy0), .dramw_ack(ak0), .o_dramwa(wa0), .o_dramwd(wd0),
    .o_dramw_mask(wm0), .o_nwrite(nw0));

  warp_write_merger #(.VSIZE(V), .CSIZE(C), .GBW(AW), .DBW(DW), .MERGE(1), .CNT_BW(16)) u_m1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .addrval_rdy(ar1), .addrval_ack(aack1), .i_address(addr_in), .i_valid(v_in),
    .alu_dat_rdy(ar1), .alu_dat_ack(dack1), .i_alu_dat(dat_in),
    .flush_dval(fi1), .flushed_dval(fl1),
    .dramw_rdy(drdy1), .dramw_ack(ak1), .o_dramwa(wa1), .o_dramwd(wd1),
    .o_dramw_mask(wm1), .o_nwrite(nw1));

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, one open line (valid, tag, words, mask).
  wr_t         exp_q[$];
  wr_t         log_q[$];
  bit          mb_v [2];
  int          mb_t [2];
  logic [15:0] mb_w [2][4];
  logic [3:0]  mb_m [2];
  int          exp_nw [2];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    log_q.delete();
    for (int k = 0; k < 2; k++) begin
      mb_v[k] = 0; mb_t[k] = 0; mb_m[k] = '0; exp_nw[k] = 0;
      for (int j = 0; j < 4; j++) mb_w[k][j] = '0;
    end
  endfunction

  function automatic void m_emit(int k);
    wr_t w;
    w.a = 16'(mb_t[k] * 4);
    w.d = {mb_w[k][3], mb_w[k][2], mb_w[k][1], mb_w[k][0]};
    w.m = mb_m[k];
    exp_q.push_back(w);
    mb_v[k] = 0;
    mb_m[k] = '0;
  endfunction

  function automatic void m_flush(int k);
    if (mb_v[k]) m_emit(k);
  endfunction

  // Instance 0 is the non-merging one: every group is written on its own.
  function automatic void m_warp(int k, logic [63:0] a, logic [3:0] v, logic [63:0] d);
    logic [3:0] r;
    int lo, t, off;
    r = v;
    while (r != 0) begin
      lo = 0;
      for (int i = 3; i >= 0; i--) if (r[i]) lo = i;
      t = int'(a[lo*16 +: 16]) / 4;
      if (mb_v[k] && mb_t[k] != t) m_emit(k);
      for (int i = 0; i < 4; i++) begin
        if (r[i] && (int'(a[i*16 +: 16]) / 4 == t)) begin
          off = int'(a[i*16 +: 16]) % 4;
          mb_w[k][off] = d[i*16 +: 16];
          mb_m[k][off] = 1'b1;
          r[i] = 1'b0;
        end
      end
      mb_v[k] = 1;
      mb_t[k] = t;
      if (k == 0) m_emit(k);
    end
  endfunction

  always @(posedge clk) begin
    if (rst_n && cur_drdy && dram_ack) begin
      wr_t w;
      w.a = cur_wa; w.d = cur_wd; w.m = cur_wm;
      log_q.push_back(w);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      exp_nw[sel]++;
    end
  end

  always @(negedge clk) begin
    #3;
    if (rst_n && mon_en) begin
      chk("ack_join", {63'd0, cur_aack}, {63'd0, cur_dack});
      chk("nwrite", {48'd0, cur_nw}, 64'(exp_nw[sel] % 65536));
      if (cur_drdy) begin
        chk("ack_in_emit", {63'd0, cur_aack}, 64'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write got_addr=%0h want=none", cur_wa);
        end else begin
          chk("wr_addr", {48'd0, cur_wa}, {48'd0, exp_q[0].a});
          chk("wr_mask", {60'd0, cur_wm}, {60'd0, exp_q[0].m});
          for (int j = 0; j < 4; j++)
            if (exp_q[0].m[j]) chk("wr_word", {48'd0, cur_wd[j*16 +: 16]}, {48'd0, exp_q[0].d[j*16 +: 16]});
        end
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
    dram_ack = cur_drdy & ~hold;
  endtask

  task automatic do_reset(input logic s);
    rst_n = 1'b0; rdy = 0; flush = 0; dram_ack = 0; hold = 0;
    addr_in = '0; v_in = '0; dat_in = '0;
    model_clear();
    sel = s;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [63:0] a, input logic [3:0] v, input logic [63:0] d);
    bit got;
    got = 0;
    @(negedge clk);
    addr_in = a; v_in = v; dat_in = d; rdy = 1'b1;
    #1; dram_ack = cur_drdy & ~hold;
    for (int n = 0; n < 100; n++) begin
      if (cur_aack) begin got = 1; break; end
      step();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL warp_ack_timeout got=0 want=1");
    end else begin
      m_warp(int'(sel), a, v, d);
      @(posedge clk); #1;
    end
    rdy = 1'b0;
  endtask

  task automatic do_flush(input int want_lat);
    int lat;
    m_flush(int'(sel));
    @(negedge clk); flush = 1'b1;
    #1; dram_ack = cur_drdy & ~hold;
    step(); flush = 1'b0; lat = 1;
    while (!cur_fl && lat < 200) begin step(); lat++; end
    checks++;
    if (!cur_fl) begin
      errors++;
      $display("FAIL flush_timeout got=0 want=1");
    end else if (want_lat > 0) begin
      chk("flush_latency", 64'(lat), 64'(want_lat));
    end
    step();
    chk("flushed_one_cycle", {63'd0, cur_fl}, 64'd0);
    chk("flush_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_emit();
    for (int n = 0; n < 30; n++) begin
      if (cur_drdy) break;
      step();
    end
    chk("emit_reached", {63'd0, cur_drdy}, 64'd1);
  endtask

  localparam logic [15:0] A = 16'hAAAA, B = 16'hBBBB, CC = 16'hCCCC, D = 16'hDDDD;

  initial begin
    // Reset state of both instances.
    do_reset(1'b1);
    #1;
    chk("rst_drdy", {63'd0, drdy1}, 64'd0);
    chk("rst_aack", {63'd0, aack1}, 64'd0);
    chk("rst_flushed", {63'd0, fl1}, 64'd0);
    chk("rst_nwrite1", {48'd0, nw1}, 64'd0);
    chk("rst_nwrite0", {48'd0, nw0}, 64'd0);
    chk("rst_wa", {48'd0, wa1}, 64'd0);
    chk("rst_wm", {60'd0, wm1}, 64'd0);
    chk("rst_wd", wd1, 64'd0);
    mon_en = 1'b1;

    // Group split: lanes 0,1,3 share line 0, lane 2 is on line 1.
    send({16'd2, 16'd5, 16'd1, 16'd0}, 4'b1111, {D, CC, B, A});
    do_flush(-1);
    chk("split_nwr", 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) begin
      chk("split_a0", {48'd0, log_q[0].a}, 64'd0);
      chk("split_m0", {60'd0, log_q[0].m}, 64'b0111);
      chk("split_w0", {48'd0, log_q[0].d[15:0]},  {48'd0, A});
      chk("split_w1", {48'd0, log_q[0].d[31:16]}, {48'd0, B});
      chk("split_w2", {48'd0, log_q[0].d[47:32]}, {48'd0, D});
      chk("split_a1", {48'd0, log_q[1].a}, 64'd4);
      chk("split_m1", {60'd0, log_q[1].m}, 64'b0010);
      chk("split_w1b", {48'd0, log_q[1].d[31:16]}, {48'd0, CC});
    end
    chk("split_cnt", {48'd0, cur_nw}, 64'd2);

    // Cross-warp merge into one line.
    do_reset(1'b1);
    send({48'd0, 16'd8}, 4'b0001, {48'd0, 16'h0011});
    send({16'd0, 16'd11, 16'd10, 16'd9}, 4'b0111, {16'd0, 16'h0023, 16'h0022, 16'h0021});
    do_flush(-1);
    chk("merge_nwr", 64'(log_q.size()), 64'd1);
    if (log_q.size() >= 1) begin
      chk("merge_a", {48'd0, log_q[0].a}, 64'd8);
      chk("merge_m", {60'd0, log_q[0].m}, 64'b1111);
      chk("merge_d", log_q[0].d, 64'h0023_0022_0021_0011);
    end
    chk("merge_cnt", {48'd0, cur_nw}, 64'd1);

    // Word conflict: highest lane wins.
    do_reset(1'b1);
    send({16'd3, 16'd3, 16'd3, 16'd3}, 4'b1111, {D, CC, B, A});
    do_flush(-1);
    chk("conf_nwr", 64'(log_q.size()), 64'd1);
    if (log_q.size() >= 1) begin
      chk("conf_a", {48'd0, log_q[0].a}, 64'd0);
      chk("conf_m", {60'd0, log_q[0].m}, 64'b1000);
      chk("conf_w3", {48'd0, log_q[0].d[63:48]}, {48'd0, D});
    end

    // Backpressure: a held EMIT keeps its outputs and blocks the next warp.
    do_reset(1'b1);
    hold = 1'b1;
    send({32'd0, 16'd5, 16'd4}, 4'b0011, {32'd0, 16'h0022, 16'h0011});
    send({48'd0, 16'd8}, 4'b0001, {48'd0, 16'h0033});
    wait_emit();
    addr_in = {48'd0, 16'd9}; v_in = 4'b0001; dat_in = {48'd0, 16'h0044}; rdy = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("bp_rdy", {63'd0, cur_drdy}, 64'd1);
      chk("bp_wa", {48'd0, cur_wa}, 64'd4);
      chk("bp_wm", {60'd0, cur_wm}, 64'b0011);
      chk("bp_wd", {32'd0, cur_wd[31:0]}, 64'h0022_0011);
      chk("bp_aack", {63'd0, cur_aack}, 64'd0);
      chk("bp_dack", {63'd0, cur_dack}, 64'd0);
    end
    chk("bp_nowrite", 64'(log_q.size()), 64'd0);
    hold = 1'b0;
    send({48'd0, 16'd9}, 4'b0001, {48'd0, 16'h0044});
    chk("bp_onewrite", 64'(log_q.size()), 64'd1);
    do_flush(-1);
    chk("bp_nwr", 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) begin
      chk("bp_a1", {48'd0, log_q[1].a}, 64'd8);
      chk("bp_m1", {60'd0, log_q[1].m}, 64'b0011);
      chk("bp_d1", {32'd0, log_q[1].d[31:0]}, 64'h0044_0033);
    end

    // Flush with an empty buffer.
    do_reset(1'b1);
    do_flush(2);
    chk("idleflush_cnt", {48'd0, cur_nw}, 64'd0);

    // Non-merging instance: every group is its own write.
    do_reset(1'b0);
    send({48'd0, 16'd8}, 4'b0001, {48'd0, 16'h0011});
    send({16'd0, 16'd11, 16'd10, 16'd9}, 4'b0111, {16'd0, 16'h0023, 16'h0022, 16'h0021});
    do_flush(-1);
    chk("m0_nwr", 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) begin
      chk("m0_a0", {48'd0, log_q[0].a}, 64'd8);
      chk("m0_m0", {60'd0, log_q[0].m}, 64'b0001);
      chk("m0_a1", {48'd0, log_q[1].a}, 64'd8);
      chk("m0_m1", {60'd0, log_q[1].m}, 64'b1110);
    end
    chk("m0_cnt", {48'd0, cur_nw}, 64'd2);

    // Reset during EMIT drops the line and the count.
    do_reset(1'b1);
    send({48'd0, 16'd0}, 4'b0001, {48'd0, 16'h0001});
    send({48'd0, 16'd4}, 4'b0001, {48'd0, 16'h0002});
    send({48'd0, 16'd8}, 4'b0001, {48'd0, 16'h0003});
    repeat (10) step();
    chk("pre_rst_cnt", {48'd0, cur_nw}, 64'd2);
    hold = 1'b1;
    send({48'd0, 16'd12}, 4'b0001, {48'd0, 16'h0004});
    wait_emit();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_emit_rdy", {63'd0, cur_drdy}, 64'd0);
    chk("rst_emit_cnt", {48'd0, cur_nw}, 64'd0);
    chk("rst_emit_aack", {63'd0, cur_aack}, 64'd0);
    model_clear();
    hold = 1'b0; dram_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_flush(2);
    chk("post_rst_cnt", {48'd0, cur_nw}, 64'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=done");
    $fatal(1, "timeout");
  end

endmodule
